// File: rtl/csa.sv
// ============================================================================
// Module   : csa
// Purpose  : 16-bit carry-select adder (4-bit blocks) with registered result.
//            Optional input register stage enabled by `define CSA_INPUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        out_valid
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_cin;
  logic        w_vld;

`ifdef CSA_INPUT_REG_EN
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_cin;
  logic        r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= 16'h0000;
      r_b   <= 16'h0000;
      r_cin <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_a   <= a;
      r_b   <= b;
      r_cin <= c_in;
      r_vld <= in_valid;
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_cin = r_cin;
  assign w_vld = r_vld;
`else
  assign w_a   = a;
  assign w_b   = b;
  assign w_cin = c_in;
  assign w_vld = in_valid;
`endif

  logic [15:0] w_sum;
  logic [4:1]  w_bc;     // w_bc[k] is the carry into block k
  logic [4:0]  w_c0;

  // Block 0: plain ripple chain fed by the external carry-in.
  assign w_c0[0] = w_cin;
  for (genvar i = 0; i < 4; i++) begin : g_blk0
    assign w_sum[i]  = w_a[i] ^ w_b[i] ^ w_c0[i];
    assign w_c0[i+1] = (w_a[i] & w_b[i]) | (w_c0[i] & (w_a[i] ^ w_b[i]));
  end
  assign w_bc[1] = w_c0[4];

  // Blocks 1-3: both carry hypotheses computed up front, selected by the incoming carry.
  for (genvar k = 1; k < 4; k++) begin : g_sel
    logic [4:0] w_cz;
    logic [4:0] w_co;
    logic [3:0] w_sz;
    logic [3:0] w_so;

    assign w_cz[0] = 1'b0;
    assign w_co[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_fa
      assign w_sz[i]   = w_a[4*k+i] ^ w_b[4*k+i] ^ w_cz[i];
      assign w_cz[i+1] = (w_a[4*k+i] & w_b[4*k+i]) | (w_cz[i] & (w_a[4*k+i] ^ w_b[4*k+i]));
      assign w_so[i]   = w_a[4*k+i] ^ w_b[4*k+i] ^ w_co[i];
      assign w_co[i+1] = (w_a[4*k+i] & w_b[4*k+i]) | (w_co[i] & (w_a[4*k+i] ^ w_b[4*k+i]));
    end

    assign w_sum[4*k+3:4*k] = w_bc[k] ? w_so : w_sz;
    assign w_bc[k+1]        = w_bc[k] ? w_co[4] : w_cz[4];
  end

  logic [15:0] r_sum;
  logic        r_cout;
  logic        r_ovld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 16'h0000;
      r_cout <= 1'b0;
      r_ovld <= 1'b0;
    end else begin
      r_ovld <= w_vld;
      if (w_vld) begin
        r_sum  <= w_sum;
        r_cout <= w_bc[4];
      end
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign out_valid = r_ovld;

endmodule

`default_nettype wire

// File: tb/tb_csa.sv
// ============================================================================
// Module   : tb_csa
// Purpose  : Self-checking bench for csa: directed table, streaming/hold,
//            reset corner cases and random operands vs a 17-bit reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa;

`ifdef CSA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [15:0] sum;
  logic        c_out;
  logic        out_valid;

  csa dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Expected output-stage state (and input stage when enabled).
  logic        m_vld  = 1'b0;
  logic [15:0] m_sum  = 16'h0000;
  logic        m_cout = 1'b0;
`ifdef CSA_INPUT_REG_EN
  logic        s_vld  = 1'b0;
  logic [16:0] s_res  = 17'h0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model at the edge, check outputs.
  task automatic cycle(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc);
    logic [16:0] res;
    in_valid = v;
    a        = ta;
    b        = tb;
    c_in     = tc;
    res      = {1'b0, ta} + {1'b0, tb} + {16'h0, tc};
    @(posedge clk);
    if (rst) begin
      m_vld  = 1'b0;
      m_sum  = 16'h0000;
      m_cout = 1'b0;
`ifdef CSA_INPUT_REG_EN
      s_vld  = 1'b0;
      s_res  = 17'h0;
`endif
    end else begin
`ifdef CSA_INPUT_REG_EN
      m_vld = s_vld;
      if (s_vld) {m_cout, m_sum} = s_res;
      s_vld = v;
      s_res = res;
`else
      m_vld = v;
      if (v) {m_cout, m_sum} = res;
`endif
    end
    @(negedge clk);
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_vld});
    chk("sum",       {16'h0, sum},       {16'h0, m_sum});
    chk("c_out",     {31'h0, c_out},     {31'h0, m_cout});
  endtask

  initial begin
    tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
    tbl[3] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    tbl[4] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    tbl[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[8] = '{16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0};
    tbl[9] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0;

    // Reset values.
    cycle(1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0);
    chk("reset_sum",   {16'h0, sum},       32'h0);
    chk("reset_cout",  {31'h0, c_out},     32'h0);
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    rst = 1'b0;
    cycle(1'b0, 16'h0, 16'h0, 1'b0);

    // Directed table with hand-computed results.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      repeat (LAT - 1) cycle(1'b0, 16'h0, 16'h0, 1'b0);
      chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("tbl%0d_sum", i),   {16'h0, sum},       {16'h0, tbl[i].exp_sum});
      chk($sformatf("tbl%0d_cout", i),  {31'h0, c_out},     {31'h0, tbl[i].exp_cout});
      cycle(1'b0, 16'h5555, 16'hAAAA, 1'b1);
      chk($sformatf("tbl%0d_hold", i),  {16'h0, sum},       {16'h0, tbl[i].exp_sum});
    end

    // Streaming then hold.
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0);
    cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    cycle(1'b1, 16'hFFF0, 16'h0010, 1'b1);
    repeat (2) cycle(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    repeat (LAT) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    chk("stream_hold_sum",  {16'h0, sum},   32'h0001);
    chk("stream_hold_cout", {31'h0, c_out}, 32'h1);

    // Reset overrides a valid operand; nothing for it ever appears.
    rst = 1'b1;
    cycle(1'b1, 16'h1234, 16'h1111, 1'b0);
    chk("rst_ovr_sum",   {16'h0, sum},       32'h0);
    chk("rst_ovr_cout",  {31'h0, c_out},     32'h0);
    chk("rst_ovr_valid", {31'h0, out_valid}, 32'h0);
    rst = 1'b0;
    repeat (LAT + 1) cycle(1'b0, 16'h0, 16'h0, 1'b0);

    // Reset mid-stream drops in-flight results.
    cycle(1'b1, 16'h4321, 16'h1111, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 16'h9999, 16'h1111, 1'b0);
    rst = 1'b0;
    repeat (LAT + 1) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b1, 16'h0FFF, 16'h0001, 1'b0);
    repeat (LAT - 1) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
    chk("post_rst_sum",   {16'h0, sum},       32'h1000);

    // Random operands against the 17-bit reference.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 8) != 0, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    repeat (LAT) cycle(1'b0, 16'h0, 16'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
